rf_wb_scheduler: RTL and testbench

- Sits between the issue stage, the two writeback sources (ALU and MEM) and the 32x32 register bank.
- Keeps a per-register busy scoreboard and stalls issue on RAW and WAW hazards against pending writes.
- Arbitrates the bank's single write port between the two writeback sources, round-robin.
- Drives the bank's write address, data and write-enable from registers.

---
 rtl/rf_wb_scheduler_pkg.sv | 14 +
 rtl/rf_wb_scheduler_rr_arbiter2.sv | 33 +++
 rtl/rf_wb_scheduler.sv | 95 +++++++++
 tb/tb_rf_wb_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_scheduler_pkg.sv
// Shared register-file constants and writeback source identifiers.
// The register bank and the writeback scheduler both size themselves from here.
package rf_pkg;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/rf_wb_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter with a one-hot grant.
// The priority pointer only moves when both requesters compete.
module rr_arbiter2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  src_e prio;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (prio == SRC_ALU) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= SRC_ALU;
    end else if (req == 2'b11) begin
      prio <= (prio == SRC_ALU) ? SRC_MEM : SRC_ALU;
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register writeback scheduler: busy scoreboard for issue hazards, round-robin
// arbitration of the bank write port between ALU and MEM, registered write port.
module rf_wb_scheduler #(
  parameter int NREGS = rf_pkg::NREGS,
  parameter int AW    = rf_pkg::AW,
  parameter int DW    = rf_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rs1,
  input  logic [AW-1:0] issue_rs2,
  input  logic [AW-1:0] issue_rd,
  input  logic          issue_has_rd,
  output logic          issue_stall,
  input  logic          alu_wb_valid,
  input  logic [AW-1:0] alu_wb_rd,
  input  logic [DW-1:0] alu_wb_data,
  output logic          alu_wb_ready,
  input  logic          mem_wb_valid,
  input  logic [AW-1:0] mem_wb_rd,
  input  logic [DW-1:0] mem_wb_data,
  output logic          mem_wb_ready,
  output logic          rf_write,
  output logic [AW-1:0] rf_addr_d,
  output logic [DW-1:0] rf_data,
  output logic [AW:0]   busy_count,
  output logic          wb_err
);

  import rf_pkg::*;

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [1:0]       grant;
  logic             wb_fire;
  logic [AW-1:0]    wb_rd;
  logic [DW-1:0]    wb_data;
  logic             set_en;
  logic             clr_en;
  logic             cnt_inc;
  logic             cnt_dec;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({mem_wb_valid, alu_wb_valid}),
    .grant (grant)
  );

  assign alu_wb_ready = grant[SRC_ALU];
  assign mem_wb_ready = grant[SRC_MEM];
  assign wb_fire      = |grant;
  assign wb_rd        = grant[SRC_MEM] ? mem_wb_rd   : alu_wb_rd;
  assign wb_data      = grant[SRC_MEM] ? mem_wb_data : alu_wb_data;

  // busy[0] is never set, so r0 operands and r0 destinations never stall.
  assign issue_stall = issue_valid &
                       (busy[issue_rs1] | busy[issue_rs2] | (issue_has_rd & busy[issue_rd]));

  assign set_en = issue_valid & ~issue_stall & issue_has_rd & (issue_rd != '0);
  // The bank captures the write on the same edge the scoreboard releases the register.
  assign clr_en = rf_write;

  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[rf_addr_d] = 1'b0;
    if (set_en) busy_next[issue_rd]  = 1'b1;
  end

  assign cnt_inc = set_en & ~busy[issue_rd];
  assign cnt_dec = clr_en & busy[rf_addr_d] & ~(set_en & (issue_rd == rf_addr_d));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
      rf_write   <= 1'b0;
      rf_addr_d  <= '0;
      rf_data    <= '0;
      wb_err     <= 1'b0;
    end else begin
      busy       <= busy_next;
      busy_count <= busy_count + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
      rf_write   <= wb_fire & (wb_rd != '0);
      if (wb_fire) begin
        rf_addr_d <= wb_rd;
        rf_data   <= wb_data;
      end
      if (wb_fire && (wb_rd != '0) && !busy[wb_rd]) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_rf_wb_scheduler;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [AW-1:0] issue_rs1, issue_rs2, issue_rd;
  logic          issue_has_rd;
  logic          issue_stall;
  logic          alu_wb_valid;
  logic [AW-1:0] alu_wb_rd;
  logic [DW-1:0] alu_wb_data;
  logic          alu_wb_ready;
  logic          mem_wb_valid;
  logic [AW-1:0] mem_wb_rd;
  logic [DW-1:0] mem_wb_data;
  logic          mem_wb_ready;
  logic          rf_write;
  logic [AW-1:0] rf_addr_d;
  logic [DW-1:0] rf_data;
  logic [AW:0]   busy_count;
  logic          wb_err;

  int total = 0;
  int bad   = 0;

  rf_wb_scheduler #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_rd     (issue_rd),
    .issue_has_rd (issue_has_rd),
    .issue_stall  (issue_stall),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_rd    (alu_wb_rd),
    .alu_wb_data  (alu_wb_data),
    .alu_wb_ready (alu_wb_ready),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_rd    (mem_wb_rd),
    .mem_wb_data  (mem_wb_data),
    .mem_wb_ready (mem_wb_ready),
    .rf_write     (rf_write),
    .rf_addr_d    (rf_addr_d),
    .rf_data      (rf_data),
    .busy_count   (busy_count),
    .wb_err       (wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [AW-1:0] rs1, rs2, rd;
    logic          hrd;
    logic          av;
    logic [AW-1:0] ard;
    logic [DW-1:0] adata;
    logic          mv;
    logic [AW-1:0] mrd;
    logic [DW-1:0] mdata;
    logic          e_stall, e_ar, e_mr;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [AW:0]   e_bc;
    logic          e_err;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(
    input logic iv, input int rs1, input int rs2, input int rd, input logic hrd,
    input logic av, input int ard, input logic [DW-1:0] adata,
    input logic mv, input int mrd, input logic [DW-1:0] mdata,
    input logic es, input logic ear, input logic emr,
    input logic ewr, input int eaddr, input logic [DW-1:0] edata, input int ebc, input logic eerr);
    vec_t v;
    v.iv = iv; v.rs1 = AW'(rs1); v.rs2 = AW'(rs2); v.rd = AW'(rd); v.hrd = hrd;
    v.av = av; v.ard = AW'(ard); v.adata = adata;
    v.mv = mv; v.mrd = AW'(mrd); v.mdata = mdata;
    v.e_stall = es; v.e_ar = ear; v.e_mr = emr;
    v.e_wr = ewr; v.e_addr = AW'(eaddr); v.e_data = edata; v.e_bc = (AW+1)'(ebc); v.e_err = eerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0; issue_has_rd = 0;
    alu_wb_valid = 0; alu_wb_rd = '0; alu_wb_data = '0;
    mem_wb_valid = 0; mem_wb_rd = '0; mem_wb_data = '0;
  endtask

  // Advance to one time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  // Behavioural model state for the randomized run.
  bit          m_busy[NREGS];
  int          m_pend_clr;
  bit          m_alu_next;
  logic        m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic        m_err;

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_pend_clr = -1;
    m_alu_next = 1;
    m_wr = 0; m_addr = '0; m_data = '0; m_err = 0;
  endtask

  function automatic int model_count();
    int n = 0;
    foreach (m_busy[i]) n += int'(m_busy[i]);
    return n;
  endfunction

  initial begin
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;

    // Directed table starting from reset: RAW, WAW, r0 cases.
    vecs[0]  = mk(0,0,0,0,0, 0,0,0, 0,0,0,                 0,0,0, 0,0,32'h0,0,0);
    vecs[1]  = mk(1,3,4,5,1, 0,0,0, 0,0,0,                 0,0,0, 0,0,32'h0,1,0);
    vecs[2]  = mk(1,5,0,0,0, 0,0,0, 0,0,0,                 1,0,0, 0,0,32'h0,1,0);
    vecs[3]  = mk(1,5,0,0,0, 1,5,32'hDEADBEEF, 0,0,0,      1,1,0, 1,5,32'hDEADBEEF,1,0);
    vecs[4]  = mk(1,5,0,0,0, 0,0,0, 0,0,0,                 1,0,0, 0,5,32'hDEADBEEF,0,0);
    vecs[5]  = mk(1,5,0,0,0, 0,0,0, 0,0,0,                 0,0,0, 0,5,32'hDEADBEEF,0,0);
    vecs[6]  = mk(1,0,0,7,1, 0,0,0, 0,0,0,                 0,0,0, 0,5,32'hDEADBEEF,1,0);
    vecs[7]  = mk(1,0,0,7,1, 0,0,0, 0,0,0,                 1,0,0, 0,5,32'hDEADBEEF,1,0);
    vecs[8]  = mk(1,0,0,7,1, 1,7,32'h77, 0,0,0,            1,1,0, 1,7,32'h77,1,0);
    vecs[9]  = mk(1,0,0,7,1, 0,0,0, 0,0,0,                 1,0,0, 0,7,32'h77,0,0);
    vecs[10] = mk(1,0,0,7,1, 0,0,0, 0,0,0,                 0,0,0, 0,7,32'h77,1,0);
    vecs[11] = mk(1,0,0,0,1, 0,0,0, 0,0,0,                 0,0,0, 0,7,32'h77,1,0);
    vecs[12] = mk(0,0,0,0,0, 1,0,32'h1234, 0,0,0,          0,1,0, 0,0,32'h1234,1,0);
    vecs[13] = mk(0,0,0,0,0, 0,0,0, 1,7,32'h70,            0,0,1, 1,7,32'h70,1,0);
    vecs[14] = mk(0,0,0,0,0, 0,0,0, 0,0,0,                 0,0,0, 0,7,32'h70,0,0);

    for (int i = 0; i < 15; i++) begin
      issue_valid = vecs[i].iv; issue_rs1 = vecs[i].rs1; issue_rs2 = vecs[i].rs2;
      issue_rd = vecs[i].rd; issue_has_rd = vecs[i].hrd;
      alu_wb_valid = vecs[i].av; alu_wb_rd = vecs[i].ard; alu_wb_data = vecs[i].adata;
      mem_wb_valid = vecs[i].mv; mem_wb_rd = vecs[i].mrd; mem_wb_data = vecs[i].mdata;
      #3;
      check($sformatf("v%0d stall", i), 32'(issue_stall), 32'(vecs[i].e_stall));
      check($sformatf("v%0d alu_ready", i), 32'(alu_wb_ready), 32'(vecs[i].e_ar));
      check($sformatf("v%0d mem_ready", i), 32'(mem_wb_ready), 32'(vecs[i].e_mr));
      tick();
      check($sformatf("v%0d rf_write", i), 32'(rf_write), 32'(vecs[i].e_wr));
      check($sformatf("v%0d rf_addr_d", i), 32'(rf_addr_d), 32'(vecs[i].e_addr));
      check($sformatf("v%0d rf_data", i), rf_data, vecs[i].e_data);
      check($sformatf("v%0d busy_count", i), 32'(busy_count), 32'(vecs[i].e_bc));
      check($sformatf("v%0d wb_err", i), 32'(wb_err), 32'(vecs[i].e_err));
    end

    // Two-way conflict from reset: ALU, MEM, ALU.
    do_reset();
    alu_wb_valid = 1; alu_wb_rd = 5'd1; alu_wb_data = 32'hA1;
    mem_wb_valid = 1; mem_wb_rd = 5'd2; mem_wb_data = 32'hB2;
    for (int k = 0; k < 3; k++) begin
      #3;
      check($sformatf("conflict%0d alu_ready", k), 32'(alu_wb_ready), 32'((k % 2) == 0));
      check($sformatf("conflict%0d mem_ready", k), 32'(mem_wb_ready), 32'((k % 2) == 1));
      tick();
      check($sformatf("conflict%0d rf_addr_d", k), 32'(rf_addr_d), ((k % 2) == 0) ? 32'd1 : 32'd2);
      check($sformatf("conflict%0d rf_write", k), 32'(rf_write), 32'd1);
    end

    // Writeback to a non-busy register flags a sticky error but still writes.
    do_reset();
    mem_wb_valid = 1; mem_wb_rd = 5'd9; mem_wb_data = 32'h99;
    #3;
    check("err mem_ready", 32'(mem_wb_ready), 32'd1);
    tick();
    idle_inputs();
    check("err rf_write", 32'(rf_write), 32'd1);
    check("err rf_addr_d", 32'(rf_addr_d), 32'd9);
    check("err wb_err", 32'(wb_err), 32'd1);
    tick();
    tick();
    check("err sticky", 32'(wb_err), 32'd1);

    // Reset with three registers busy and a writeback in flight.
    for (int r = 10; r < 13; r++) begin
      issue_valid = 1; issue_has_rd = 1; issue_rd = AW'(r);
      tick();
    end
    idle_inputs();
    check("rst pre busy_count", 32'(busy_count), 32'd3);
    rst = 1;
    alu_wb_valid = 1; alu_wb_rd = 5'd10; alu_wb_data = 32'h55;
    tick();
    rst = 0;
    idle_inputs();
    check("rst rf_write", 32'(rf_write), 32'd0);
    check("rst rf_addr_d", 32'(rf_addr_d), 32'd0);
    check("rst rf_data", rf_data, 32'd0);
    check("rst busy_count", 32'(busy_count), 32'd0);
    check("rst wb_err", 32'(wb_err), 32'd0);
    issue_valid = 1; issue_rs1 = 5'd10; issue_rs2 = 5'd11; issue_rd = 5'd12; issue_has_rd = 1;
    #3;
    check("rst no stall", 32'(issue_stall), 32'd0);
    tick();

    // Randomized run against the behavioural model.
    do_reset();
    model_reset();
    begin
      bit alu_pend = 0;
      bit mem_pend = 0;
      bit last_stall = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        int g;
        logic [AW-1:0] grd;
        logic [DW-1:0] gdata;
        bit exp_stall;

        rst = ($urandom_range(0, 199) == 0);
        if (!(issue_valid && last_stall)) begin
          issue_valid  = $urandom_range(0, 1);
          issue_rs1    = AW'($urandom_range(0, 7));
          issue_rs2    = AW'($urandom_range(0, 7));
          issue_rd     = AW'($urandom_range(0, 7));
          issue_has_rd = $urandom_range(0, 3) != 0;
        end
        if (!alu_pend && $urandom_range(0, 2) != 0) begin
          alu_pend = 1; alu_wb_rd = AW'($urandom_range(0, 7)); alu_wb_data = $urandom;
        end
        if (!mem_pend && $urandom_range(0, 2) != 0) begin
          mem_pend = 1; mem_wb_rd = AW'($urandom_range(0, 7)); mem_wb_data = $urandom;
        end
        alu_wb_valid = alu_pend;
        mem_wb_valid = mem_pend;

        // Hazard and grant decision from the current scoreboard.
        exp_stall = issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] ||
                                    (issue_has_rd && m_busy[issue_rd]));
        g = 0;
        if (alu_pend && mem_pend) begin
          g = m_alu_next ? 1 : 2;
          m_alu_next = !m_alu_next;
        end else if (alu_pend) g = 1;
        else if (mem_pend) g = 2;
        grd   = (g == 2) ? mem_wb_rd : alu_wb_rd;
        gdata = (g == 2) ? mem_wb_data : alu_wb_data;

        #3;
        check($sformatf("rand%0d stall", cyc), 32'(issue_stall), 32'(exp_stall));
        check($sformatf("rand%0d alu_ready", cyc), 32'(alu_wb_ready), 32'(g == 1));
        check($sformatf("rand%0d mem_ready", cyc), 32'(mem_wb_ready), 32'(g == 2));
        last_stall = exp_stall;

        if (rst) begin
          model_reset();
          alu_pend = 0;
          mem_pend = 0;
          last_stall = 0;
        end else begin
          if (g != 0 && grd != 0 && !m_busy[grd]) m_err = 1;
          if (m_pend_clr >= 0) m_busy[m_pend_clr] = 0;
          if (issue_valid && !exp_stall && issue_has_rd && issue_rd != 0) m_busy[issue_rd] = 1;
          m_pend_clr = (g != 0 && grd != 0) ? int'(grd) : -1;
          m_wr = (g != 0 && grd != 0);
          if (g != 0) begin
            m_addr = grd;
            m_data = gdata;
          end
          if (g == 1) alu_pend = 0;
          if (g == 2) mem_pend = 0;
        end

        tick();
        check($sformatf("rand%0d rf_write", cyc), 32'(rf_write), 32'(m_wr));
        check($sformatf("rand%0d rf_addr_d", cyc), 32'(rf_addr_d), 32'(m_addr));
        check($sformatf("rand%0d rf_data", cyc), rf_data, m_data);
        check($sformatf("rand%0d busy_count", cyc), 32'(busy_count), 32'(model_count()));
        check($sformatf("rand%0d wb_err", cyc), 32'(wb_err), 32'(m_err));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
